fetch_resp: RTL and testbench

FETCH_RESP -- requirements
Module: fetch_resp

---
 rtl/fetch_resp_if.sv | 55 +++++
 rtl/fetch_resp.sv | 121 ++++++++++++
 tb/tb_fetch_resp.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_resp_if.sv
// Fetch-side handshake bundle: fetch request, instruction bus, and decode delivery.
// The slave modport is the fetch_resp view; master is the surrounding pipeline/bus.
interface fetch_resp_if;
  logic [31:0] f_pc;
  logic        f_vreq;
  logic        f_ready;
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        ireq_ready;
  logic        iresp_valid;
  logic [31:0] iresp_data;
  logic        flush;
  logic        d_valid;
  logic [31:0] d_pc;
  logic [31:0] d_instr;
  logic        d_exc;
  logic        d_ready;
  logic        busy;

  modport slave (
    input  f_pc,
    input  f_vreq,
    input  ireq_ready,
    input  iresp_valid,
    input  iresp_data,
    input  flush,
    input  d_ready,
    output f_ready,
    output ireq_valid,
    output ireq_addr,
    output d_valid,
    output d_pc,
    output d_instr,
    output d_exc,
    output busy
  );

  modport master (
    output f_pc,
    output f_vreq,
    output ireq_ready,
    output iresp_valid,
    output iresp_data,
    output flush,
    output d_ready,
    input  f_ready,
    input  ireq_valid,
    input  ireq_addr,
    input  d_valid,
    input  d_pc,
    input  d_instr,
    input  d_exc,
    input  busy
  );
endinterface

// File: rtl/fetch_resp.sv
// Single-outstanding instruction fetch sequencer: issues one bus read per accepted PC,
// buffers the response and presents it to decode, with flush and drain of stale responses.
module fetch_resp (
  input  logic               clk,
  input  logic               reset,
  fetch_resp_if.slave        fetch_io
);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StHold,
    StDrain
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        exc_q, exc_d;

  logic        accept;

  assign accept = (state_q == StIdle) & fetch_io.f_vreq & ~fetch_io.flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      pc_q    <= 32'h0;
      instr_q <= 32'h0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      exc_q   <= exc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    exc_d   = exc_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          pc_d = fetch_io.f_pc;
          if (fetch_io.f_pc[1:0] == 2'b00) begin
            state_d = StReq;
          end else begin
            // Misaligned PC: skip the bus and deliver an address-error bubble.
            state_d = StHold;
            instr_d = 32'h0;
            exc_d   = 1'b1;
          end
        end
      end
      StReq: begin
        if (fetch_io.flush) begin
          // An address accepted in the same cycle is on the bus; its response must be eaten.
          state_d = fetch_io.ireq_ready ? StDrain : StIdle;
        end else if (fetch_io.ireq_ready) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (fetch_io.flush) begin
          state_d = fetch_io.iresp_valid ? StIdle : StDrain;
        end else if (fetch_io.iresp_valid) begin
          state_d = StHold;
          instr_d = fetch_io.iresp_data;
          exc_d   = 1'b0;
        end
      end
      StHold: begin
        if (fetch_io.flush || fetch_io.d_ready) begin
          state_d = StIdle;
        end
      end
      StDrain: begin
        if (fetch_io.iresp_valid) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are forced low while reset is held so nothing leaks from a stale state.
  always_comb begin
    fetch_io.f_ready    = 1'b0;
    fetch_io.ireq_valid = 1'b0;
    fetch_io.ireq_addr  = 32'h0;
    fetch_io.d_valid    = 1'b0;
    fetch_io.d_pc       = 32'h0;
    fetch_io.d_instr    = 32'h0;
    fetch_io.d_exc      = 1'b0;
    fetch_io.busy       = 1'b0;
    if (!reset) begin
      fetch_io.busy = (state_q != StIdle);
      unique case (state_q)
        StIdle: begin
          fetch_io.f_ready = ~fetch_io.flush;
        end
        StReq: begin
          fetch_io.ireq_valid = 1'b1;
          fetch_io.ireq_addr  = pc_q;
        end
        StHold: begin
          fetch_io.d_valid = 1'b1;
          fetch_io.d_pc    = pc_q;
          fetch_io.d_instr = instr_q;
          fetch_io.d_exc   = exc_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_resp.sv
// Directed bench for fetch_resp: a per-cycle vector table plus latency sequences.
module tb_fetch_resp;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  fetch_resp_if bus ();

  fetch_resp dut (
    .clk      (clk),
    .reset    (reset),
    .fetch_io (bus)
  );

  // exp = {f_ready, ireq_valid, ireq_addr, d_valid, d_pc, d_instr, d_exc, busy}
  typedef struct {
    logic         rst;
    logic [31:0]  pc;
    logic         vreq;
    logic         irdy;
    logic         rvld;
    logic [31:0]  rdata;
    logic         fl;
    logic         drdy;
    logic [100:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic add(input logic rst, input logic [31:0] pc, input logic vreq,
                     input logic irdy, input logic rvld, input logic [31:0] rdata,
                     input logic fl, input logic drdy,
                     input logic e_fr, input logic e_iv, input logic [31:0] e_ia,
                     input logic e_dv, input logic [31:0] e_dpc, input logic [31:0] e_di,
                     input logic e_dx, input logic e_bz);
    vec_t v;
    v.rst = rst; v.pc = pc; v.vreq = vreq; v.irdy = irdy; v.rvld = rvld;
    v.rdata = rdata; v.fl = fl; v.drdy = drdy;
    v.exp = {e_fr, e_iv, e_ia, e_dv, e_dpc, e_di, e_dx, e_bz};
    vecs.push_back(v);
  endtask

  function automatic logic [100:0] outs();
    return {bus.f_ready, bus.ireq_valid, bus.ireq_addr, bus.d_valid, bus.d_pc,
            bus.d_instr, bus.d_exc, bus.busy};
  endfunction

  task automatic check(input string name, input logic [100:0] got, input logic [100:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic drive_idle();
    reset = 1'b0; bus.f_pc = 32'h0; bus.f_vreq = 1'b0; bus.ireq_ready = 1'b0;
    bus.iresp_valid = 1'b0; bus.iresp_data = 32'h0; bus.flush = 1'b0; bus.d_ready = 1'b0;
  endtask

  // Accept pc, then hold bus/decode ready; returns cycles from accept to d_valid.
  task automatic run_fetch(input logic [31:0] pc, input logic [31:0] data,
                           output int lat, output int n_ireq, output logic [100:0] dout);
    @(negedge clk);
    drive_idle();
    bus.f_pc = pc; bus.f_vreq = 1'b1;
    lat = 0; n_ireq = 0;
    @(negedge clk);
    bus.f_vreq = 1'b0; bus.ireq_ready = 1'b1; bus.iresp_valid = 1'b1;
    bus.iresp_data = data; bus.d_ready = 1'b1;
    do begin
      if (lat > 0) @(negedge clk);
      #1;
      lat++;
      if (bus.ireq_valid) n_ireq++;
    end while (!bus.d_valid && lat < 10);
    dout = outs();
    @(negedge clk);
    drive_idle();
  endtask

  initial begin
    int lat, n_ireq;
    logic [100:0] dout;
    drive_idle();
    reset = 1'b1;

    //  rst pc            vq ir rv rdata         fl dr   fr iv ia            dv dpc           di            dx bz
    add(1, 32'h0,         0, 0, 0, 32'h0,        0, 0,   0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 0);
    add(1, 32'hbfc00000,  1, 1, 1, 32'h12345678, 1, 1,   0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 0);
    add(0, 32'h0,         0, 0, 0, 32'h0,        0, 0,   1, 0, 32'h0,        0, 32'h0,        32'h0,        0, 0);
    // Boot fetch, minimum latency
    add(0, 32'hbfc00000,  1, 0, 0, 32'h0,        0, 0,   1, 0, 32'h0,        0, 32'h0,        32'h0,        0, 0);
    add(0, 32'h0,         0, 1, 0, 32'h0,        0, 0,   0, 1, 32'hbfc00000, 0, 32'h0,        32'h0,        0, 1);
    add(0, 32'h0,         0, 0, 1, 32'h24080001, 0, 0,   0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 1);
    add(0, 32'h0,         0, 0, 0, 32'h0,        0, 1,   0, 0, 32'h0,        1, 32'hbfc00000, 32'h24080001, 0, 1);
    add(0, 32'h0,         0, 0, 1, 32'hffffffff, 0, 0,   1, 0, 32'h0,        0, 32'h0,        32'h0,        0, 0);
    // Misaligned PC
    add(0, 32'hbfc00002,  1, 0, 0, 32'h0,        0, 0,   1, 0, 32'h0,        0, 32'h0,        32'h0,        0, 0);
    add(0, 32'h0,         0, 1, 0, 32'h0,        0, 1,   0, 0, 32'h0,        1, 32'hbfc00002, 32'h0,        1, 1);
    // Bus back-pressure, then decode back-pressure
    add(0, 32'h00400010,  1, 0, 0, 32'h0,        0, 0,   1, 0, 32'h0,        0, 32'h0,        32'h0,        0, 0);
    add(0, 32'h0,         0, 0, 0, 32'h0,        0, 0,   0, 1, 32'h00400010, 0, 32'h0,        32'h0,        0, 1);
    add(0, 32'h0,         0, 0, 1, 32'h55555555, 0, 0,   0, 1, 32'h00400010, 0, 32'h0,        32'h0,        0, 1);
    add(0, 32'h00400099,  1, 0, 0, 32'h0,        0, 0,   0, 1, 32'h00400010, 0, 32'h0,        32'h0,        0, 1);
    add(0, 32'h0,         0, 0, 0, 32'h0,        0, 0,   0, 1, 32'h00400010, 0, 32'h0,        32'h0,        0, 1);
    add(0, 32'h0,         0, 0, 0, 32'h0,        0, 0,   0, 1, 32'h00400010, 0, 32'h0,        32'h0,        0, 1);
    add(0, 32'h0,         0, 1, 0, 32'h0,        0, 0,   0, 1, 32'h00400010, 0, 32'h0,        32'h0,        0, 1);
    add(0, 32'h0,         0, 0, 0, 32'h0,        0, 0,   0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 1);
    add(0, 32'h0,         0, 0, 1, 32'h8c220004, 0, 0,   0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 1);
    add(0, 32'h0,         0, 0, 0, 32'h0,        0, 0,   0, 0, 32'h0,        1, 32'h00400010, 32'h8c220004, 0, 1);
    add(0, 32'h00400099,  1, 0, 1, 32'h0,        0, 0,   0, 0, 32'h0,        1, 32'h00400010, 32'h8c220004, 0, 1);
    add(0, 32'h0,         0, 0, 0, 32'h0,        0, 0,   0, 0, 32'h0,        1, 32'h00400010, 32'h8c220004, 0, 1);
    add(0, 32'h0,         0, 0, 0, 32'h0,        0, 0,   0, 0, 32'h0,        1, 32'h00400010, 32'h8c220004, 0, 1);
    add(0, 32'h0,         0, 0, 0, 32'h0,        0, 1,   0, 0, 32'h0,        1, 32'h00400010, 32'h8c220004, 0, 1);
    // Flush in WAIT without response, drain the late response
    add(0, 32'h00400020,  1, 0, 0, 32'h0,        0, 0,   1, 0, 32'h0,        0, 32'h0,        32'h0,        0, 0);
    add(0, 32'h0,         0, 1, 0, 32'h0,        0, 0,   0, 1, 32'h00400020, 0, 32'h0,        32'h0,        0, 1);
    add(0, 32'h0,         0, 0, 0, 32'h0,        1, 0,   0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 1);
    add(0, 32'h0,         0, 0, 0, 32'h0,        1, 0,   0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 1);
    add(0, 32'h0,         0, 0, 0, 32'h0,        0, 0,   0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 1);
    add(0, 32'h0,         0, 0, 1, 32'hdeadbeef, 0, 1,   0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 1);
    add(0, 32'h00400030,  1, 0, 0, 32'h0,        0, 0,   1, 0, 32'h0,        0, 32'h0,        32'h0,        0, 0);
    add(0, 32'h0,         0, 1, 0, 32'h0,        0, 0,   0, 1, 32'h00400030, 0, 32'h0,        32'h0,        0, 1);
    add(0, 32'h0,         0, 0, 1, 32'h11112222, 0, 0,   0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 1);
    add(0, 32'h0,         0, 0, 0, 32'h0,        0, 1,   0, 0, 32'h0,        1, 32'h00400030, 32'h11112222, 0, 1);
    // Flush in REQ, address not taken
    add(0, 32'h00400040,  1, 0, 0, 32'h0,        0, 0,   1, 0, 32'h0,        0, 32'h0,        32'h0,        0, 0);
    add(0, 32'h0,         0, 0, 0, 32'h0,        1, 0,   0, 1, 32'h00400040, 0, 32'h0,        32'h0,        0, 1);
    add(0, 32'h0,         0, 0, 0, 32'h0,        0, 0,   1, 0, 32'h0,        0, 32'h0,        32'h0,        0, 0);
    // Flush in REQ, address taken
    add(0, 32'h00400050,  1, 0, 0, 32'h0,        0, 0,   1, 0, 32'h0,        0, 32'h0,        32'h0,        0, 0);
    add(0, 32'h0,         0, 1, 0, 32'h0,        1, 0,   0, 1, 32'h00400050, 0, 32'h0,        32'h0,        0, 1);
    add(0, 32'h0,         0, 0, 0, 32'h0,        0, 0,   0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 1);
    add(0, 32'h0,         0, 0, 1, 32'h0badf00d, 1, 0,   0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 1);
    add(0, 32'h0,         0, 0, 0, 32'h0,        0, 0,   1, 0, 32'h0,        0, 32'h0,        32'h0,        0, 0);
    // Flush in WAIT together with the response
    add(0, 32'h00400060,  1, 0, 0, 32'h0,        0, 0,   1, 0, 32'h0,        0, 32'h0,        32'h0,        0, 0);
    add(0, 32'h0,         0, 1, 0, 32'h0,        0, 0,   0, 1, 32'h00400060, 0, 32'h0,        32'h0,        0, 1);
    add(0, 32'h0,         0, 0, 1, 32'haaaa5555, 1, 0,   0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 1);
    add(0, 32'h0,         0, 0, 0, 32'h0,        0, 0,   1, 0, 32'h0,        0, 32'h0,        32'h0,        0, 0);
    // Flush in HOLD with d_ready
    add(0, 32'h00400070,  1, 0, 0, 32'h0,        0, 0,   1, 0, 32'h0,        0, 32'h0,        32'h0,        0, 0);
    add(0, 32'h0,         0, 1, 0, 32'h0,        0, 0,   0, 1, 32'h00400070, 0, 32'h0,        32'h0,        0, 1);
    add(0, 32'h0,         0, 0, 1, 32'h00000013, 0, 0,   0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 1);
    add(0, 32'h0,         0, 0, 0, 32'h0,        1, 1,   0, 0, 32'h0,        1, 32'h00400070, 32'h00000013, 0, 1);
    add(0, 32'h0,         0, 0, 0, 32'h0,        0, 0,   1, 0, 32'h0,        0, 32'h0,        32'h0,        0, 0);
    // Flush in IDLE blocks acceptance
    add(0, 32'h00400080,  1, 0, 0, 32'h0,        1, 0,   0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 0);
    add(0, 32'h0,         0, 0, 0, 32'h0,        0, 0,   1, 0, 32'h0,        0, 32'h0,        32'h0,        0, 0);
    // Reset in WAIT, stale response afterwards
    add(0, 32'h00400090,  1, 0, 0, 32'h0,        0, 0,   1, 0, 32'h0,        0, 32'h0,        32'h0,        0, 0);
    add(0, 32'h0,         0, 1, 0, 32'h0,        0, 0,   0, 1, 32'h00400090, 0, 32'h0,        32'h0,        0, 1);
    add(1, 32'h0,         0, 0, 0, 32'h0,        0, 0,   0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 0);
    add(0, 32'h0,         0, 0, 1, 32'hcafef00d, 0, 0,   1, 0, 32'h0,        0, 32'h0,        32'h0,        0, 0);
    add(0, 32'h0,         0, 0, 0, 32'h0,        0, 0,   1, 0, 32'h0,        0, 32'h0,        32'h0,        0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset = vecs[i].rst; bus.f_pc = vecs[i].pc; bus.f_vreq = vecs[i].vreq;
      bus.ireq_ready = vecs[i].irdy; bus.iresp_valid = vecs[i].rvld;
      bus.iresp_data = vecs[i].rdata; bus.flush = vecs[i].fl; bus.d_ready = vecs[i].drdy;
      #1;
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // Aligned fetch with all handshakes ready: d_valid three cycles after accept
    run_fetch(32'hbfc00000, 32'h24080001, lat, n_ireq, dout);
    check("aligned_latency", 101'(lat), 101'(3));
    check("aligned_ireq_cycles", 101'(n_ireq), 101'(1));
    check("aligned_dout", dout, {1'b0, 1'b0, 32'h0, 1'b1, 32'hbfc00000, 32'h24080001,
                                 1'b0, 1'b1});

    // Misaligned fetch: no bus request, exception delivered one cycle after accept
    run_fetch(32'hbfc00002, 32'h24080001, lat, n_ireq, dout);
    check("misaligned_latency", 101'(lat), 101'(1));
    check("misaligned_ireq_cycles", 101'(n_ireq), 101'(0));
    check("misaligned_dout", dout, {1'b0, 1'b0, 32'h0, 1'b1, 32'hbfc00002, 32'h0,
                                    1'b1, 1'b1});

    @(negedge clk);
    #1;
    check("final_idle", outs(), {1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
